vrp_arb_obuf: RTL
=================

Name: vrp_arb_obuf

Overview:
- Downstream stage of the vrp round-robin request arbiter.
- Accepts the winning index from the arbiter each cycle. Selects that requester's payload from a flattened per-source payload bus.
- Stores {idx, data} in a small FIFO with registered outputs, decoupling the arbiter from consumer back-pressure.
- Also reports occupancy and supports a synchronous flush.

Parameters:
- BIN_WIDTH, 4, width of the requester index; OH_WIDTH = 1<<BIN_WIDTH sources (localparam).
- DATA_WIDTH, 32, payload bits per source.
- DEPTH, 2, FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1) (localparam), occupancy width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all entries.
- in_vld  input  1  arbiter has a winner this cycle.
- in_rdy  output  1  buffer accepts a push this cycle.
- in_idx  input  BIN_WIDTH  winning source index.
- in_data  input  OH_WIDTH*DATA_WIDTH  flattened payloads; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_vld  output  1  head entry valid.
- out_rdy  input  1  consumer takes head.
- out_idx  output  BIN_WIDTH  head source index.
- out_data  output  DATA_WIDTH  head payload.
- occ  output  CNT_W  current entry count.

Behaviour:
- Reset values: all entries invalid, rd/wr pointers 0, occ=0, out_vld=0, out_idx=0, out_data=0, in_rdy=1.
- Push:
  - push = in_vld && in_rdy.
  - Stores {in_idx, in_data[in_idx*DATA_WIDTH +: DATA_WIDTH]} at wr_ptr.
  - wr_ptr advances modulo DEPTH.
- Pop:
  - pop = out_vld && out_rdy.
  - rd_ptr advances modulo DEPTH.
- in_rdy = (occ != DEPTH).
  - Derived only from registered state; no combinational path from out_rdy.
  - When full, a simultaneous pop does not enable a push that cycle.
- out_vld = (occ != 0). out_idx/out_data are driven from the entry at rd_ptr, which is a registered storage mux.
- Latency: push in cycle N makes the entry visible at out_* in cycle N+1 (no bypass, even when empty).
- Occupancy update:
  - push and no pop: occ+1.
  - pop and no push: occ-1.
  - both: unchanged, and pointers both advance.
- Ordering: strict FIFO; entries leave in acceptance order.
- Stability: while out_vld=1 and out_rdy=0, out_idx/out_data hold constant.
- Only the selected source's slice of in_data is sampled, and only in the push cycle. The other slices are don't-care.
- Flush:
  - Next cycle: occ=0, pointers=0, out_vld=0.
  - Flush has priority over a same-cycle push and pop; both are discarded.
  - in_rdy stays per the formula during the flush cycle.
- Empty: out_idx/out_data hold the last popped values. Storage is not cleared except by reset.
- Reset mid-operation: asynchronous assertion immediately forces all reset values.
- Assertions (simulation only):
  - no push when in_rdy=0;
  - occ never exceeds DEPTH;
  - out_idx/out_data stable under stall.

Optional Feature:
- Macro: VRP_ARB_OBUF_PERF_EN.
- Defined adds:
  - Ports: perf_clr input 1; perf_sel input BIN_WIDTH; perf_cnt output 16.
  - One 16-bit saturating counter per source, incremented on each push with in_idx==k.
  - A counter saturates at 16'hFFFF.
  - perf_clr clears all counters synchronously; it has priority over a same-cycle increment.
  - perf_cnt is the combinational read of counter[perf_sel].
  - Reset clears all counters to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single push, idle consumer:
  - Stimulus: reset; push idx=3 with slice 3 = 0xDEADBEEF and all other slices 0x0; out_rdy=0.
  - Response: next cycle out_vld=1, out_idx=3, out_data=0xDEADBEEF, occ=1.
- Fill to full:
  - Stimulus: DEPTH=2, push idx 5 then idx 9 (data 0x55, 0x99), out_rdy=0.
  - Response: occ=2, in_rdy=0. A third in_vld is not accepted. Head stays idx=5/0x55 for 10 stall cycles.
- Streaming:
  - Stimulus: in_vld=1 and out_rdy=1 continuously, idx 0..15 with data = idx*0x11.
  - Response: 16 pops in order; out_data sequence 0x00,0x11,…,0xFF; occ stays 1 after the first cycle.
- Full with simultaneous pop:
  - Stimulus: occ=2, out_rdy=1, in_vld=1.
  - Response: no push that cycle; occ=1 next cycle; push accepted the following cycle.
- Flush:
  - Stimulus: occ=2, flush=1 together with in_vld=1 and out_rdy=1.
  - Response: next cycle occ=0, out_vld=0, in_rdy=1; the flushed entries and the same-cycle push never appear on out_*.
- Perf (VRP_ARB_OBUF_PERF_EN):
  - Stimulus: 70000 pushes of idx=7, then perf_sel=7.
  - Response: perf_cnt=0xFFFF (saturated). After perf_clr, perf_cnt=0; perf_sel=2 reads 0.

Source files
------------

// File: rtl/vrp_arb_obuf.sv
// Output buffer behind the vrp round-robin arbiter: captures {winner idx, winner payload} into a small FIFO.
// Optional per-source push counters are enabled with VRP_ARB_OBUF_PERF_EN.
module vrp_arb_obuf #(
  parameter int unsigned BIN_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  localparam int unsigned OH_WIDTH  = 1 << BIN_WIDTH,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_vld,
  output logic                           in_rdy,
  input  logic [BIN_WIDTH-1:0]           in_idx,
  input  logic [OH_WIDTH*DATA_WIDTH-1:0] in_data,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic [BIN_WIDTH-1:0]           out_idx,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CNT_W-1:0]               occ
`ifdef VRP_ARB_OBUF_PERF_EN
  ,
  input  logic                           perf_clr,
  input  logic [BIN_WIDTH-1:0]           perf_sel,
  output logic [15:0]                    perf_cnt
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BIN_WIDTH-1:0]  idx_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [DATA_WIDTH-1:0] slices   [OH_WIDTH];

  logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0]      occ_nxt;
  logic [BIN_WIDTH-1:0]  idx_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  push, pop, wr_en, rd_en;
  logic                  in_rdy_nxt, out_vld_nxt;

  // Unpack the flattened payload bus so only the winner's slice is selected.
  for (genvar k = 0; k < OH_WIDTH; k++) begin : g_slice
    assign slices[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
  end
  assign sel_data = slices[in_idx];

  assign push  = in_vld && in_rdy;
  assign pop   = out_vld && out_rdy;
  assign wr_en = push && !flush;
  assign rd_en = pop && !flush;

  // Next pointers/occupancy and next head; the head register is loaded from
  // the incoming entry when it is written straight into the next head slot.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    occ_nxt    = occ;
    idx_nxt    = out_idx;
    data_nxt   = out_data;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      occ_nxt    = '0;
    end else begin
      if (wr_en) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr_nxt = rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en)      occ_nxt = occ + CNT_W'(1);
      else if (rd_en && !wr_en) occ_nxt = occ - CNT_W'(1);
      if (occ_nxt != '0) begin
        if (wr_en && (wr_ptr == rd_ptr_nxt)) begin
          idx_nxt  = in_idx;
          data_nxt = sel_data;
        end else begin
          idx_nxt  = idx_mem[rd_ptr_nxt];
          data_nxt = data_mem[rd_ptr_nxt];
        end
      end
    end
    in_rdy_nxt  = (occ_nxt != CNT_W'(DEPTH));
    out_vld_nxt = (occ_nxt != '0);
  end

  // Pointers, occupancy and registered head/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      in_rdy   <= 1'b1;
      out_vld  <= 1'b0;
      out_idx  <= '0;
      out_data <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      occ      <= occ_nxt;
      in_rdy   <= in_rdy_nxt;
      out_vld  <= out_vld_nxt;
      out_idx  <= idx_nxt;
      out_data <= data_nxt;
    end
  end

  // Entry storage; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else if (wr_en) begin
      idx_mem[wr_ptr]  <= in_idx;
      data_mem[wr_ptr] <= sel_data;
    end
  end

`ifdef VRP_ARB_OBUF_PERF_EN
  logic [15:0] perf_ctr [OH_WIDTH];

  // Per-source saturating accepted-push counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OH_WIDTH; i++) perf_ctr[i] <= '0;
    end else if (perf_clr) begin
      for (int i = 0; i < OH_WIDTH; i++) perf_ctr[i] <= '0;
    end else if (wr_en && (perf_ctr[in_idx] != 16'hFFFF)) begin
      perf_ctr[in_idx] <= perf_ctr[in_idx] + 16'd1;
    end
  end

  assign perf_cnt = perf_ctr[perf_sel];
`endif

`ifndef SYNTHESIS
  logic                  stall_q;
  logic [BIN_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      stall_q <= out_vld && !out_rdy;
      idx_q   <= out_idx;
      data_q  <= out_data;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      a_push_full: assert (!push || (occ != CNT_W'(DEPTH)));
      a_occ_max:   assert (occ <= CNT_W'(DEPTH));
      a_stall:     assert (!stall_q || ((out_idx == idx_q) && (out_data == data_q)));
    end
  end
`endif

endmodule
